// File: rtl/bicubic_line_tap_reader.sv
// bicubic_line_tap_reader: writes one source line into the four-bank line
// buffer, then walks a Q11.8 coordinate across the output line and emits one
// 4-tap group (x-1..x+2) per cycle to the horizontal bicubic filter.
// Optional feature macro: BICUBIC_EDGE_CLAMP_EN (replicates edge pixels into
// out-of-line taps). Without it raw RAM words pass through unchanged.
//
// state  | meaning
// IDLE   | waiting for start
// FILL   | accepting source pixels into the line buffer
// GAP    | one quiet cycle between the last write and the first read
// SCAN   | issuing one tap group per cycle
// FLUSH  | draining the read-latency sideband pipe
module bicubic_line_tap_reader #(
  parameter int DATA_WIDTH    = 24,
  parameter int ADDRESS_WIDTH = 11,
  parameter int FRAC_BITS     = 8,
  parameter int RD_LATENCY    = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [ADDRESS_WIDTH-1:0]           cfg_in_width,
  input  logic [ADDRESS_WIDTH-1:0]           cfg_out_width,
  input  logic [ADDRESS_WIDTH+FRAC_BITS-1:0] cfg_step,
  input  logic                               s_valid,
  input  logic [DATA_WIDTH-1:0]              s_data,
  output logic                               s_ready,
  output logic [DATA_WIDTH-1:0]              ram_data_out,
  output logic                               ram_we_out,
  output logic [ADDRESS_WIDTH-1:0]           ram_addrA_out,
  output logic [ADDRESS_WIDTH-1:0]           ram_addrB_out,
  output logic [ADDRESS_WIDTH-1:0]           ram_addrC_out,
  output logic [ADDRESS_WIDTH-1:0]           ram_addrD_out,
  input  logic [DATA_WIDTH-1:0]              ram_qA_in,
  input  logic [DATA_WIDTH-1:0]              ram_qB_in,
  input  logic [DATA_WIDTH-1:0]              ram_qC_in,
  input  logic [DATA_WIDTH-1:0]              ram_qD_in,
  output logic                               m_valid,
  output logic [DATA_WIDTH-1:0]              m_p0,
  output logic [DATA_WIDTH-1:0]              m_p1,
  output logic [DATA_WIDTH-1:0]              m_p2,
  output logic [DATA_WIDTH-1:0]              m_p3,
  output logic [FRAC_BITS-1:0]               m_frac,
  output logic                               m_last,
  output logic                               busy,
  output logic                               done
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int FW = FRAC_BITS;
  localparam int CW = ADDRESS_WIDTH + FRAC_BITS;
  localparam int RL = RD_LATENCY;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_SCAN  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  logic [2:0]    state;
  logic [AW-1:0] in_w, out_w, wr_cnt, out_cnt;
  logic [CW-1:0] step;
  logic [CW:0]   acc;

  logic [RL-1:0] pipe_v, pipe_l;
  logic [FW-1:0] pipe_f [RL];

  logic [AW-1:0] xi_raw, xi, w_m1;
  logic [FW-1:0] frac;
  logic          sat, issue, accept, last_grp;

  // Coordinate decode: integer part saturates at the last source pixel,
  // and a saturated coordinate carries no fractional phase.
  always_comb begin
    xi_raw = acc[CW-1:FW];
    w_m1   = in_w - AW'(1);
    sat    = acc[CW] | (xi_raw > w_m1);
    xi     = sat ? w_m1 : xi_raw;
    frac   = sat ? '0 : acc[FW-1:0];
  end

  assign issue    = (state == S_SCAN);
  assign accept   = (state == S_FILL) && s_valid;
  assign last_grp = (out_cnt == out_w - AW'(1));

  assign s_ready      = (state == S_FILL);
  assign busy         = (state != S_IDLE);
  assign ram_we_out   = accept;
  assign ram_data_out = accept ? s_data : '0;

  // Tap addresses stay strictly consecutive (mod 2^AW); the bank mapping relies on it.
  always_comb begin
    ram_addrA_out = '0;
    ram_addrB_out = '0;
    ram_addrC_out = '0;
    ram_addrD_out = '0;
    if (state == S_FILL) begin
      ram_addrB_out = wr_cnt;
    end else if (issue) begin
      ram_addrA_out = xi - AW'(1);
      ram_addrB_out = xi;
      ram_addrC_out = xi + AW'(1);
      ram_addrD_out = xi + AW'(2);
    end
  end

  // Control FSM with line counters and the coordinate accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      in_w    <= '0;
      out_w   <= '0;
      step    <= '0;
      wr_cnt  <= '0;
      out_cnt <= '0;
      acc     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            in_w    <= cfg_in_width;
            out_w   <= cfg_out_width;
            step    <= cfg_step;
            wr_cnt  <= '0;
            out_cnt <= '0;
            acc     <= '0;
            if (cfg_in_width == '0 || cfg_out_width == '0) done <= 1'b1;
            else state <= S_FILL;
          end
        end
        S_FILL: begin
          if (s_valid) begin
            wr_cnt <= wr_cnt + AW'(1);
            if (wr_cnt == w_m1) state <= S_GAP;
          end
        end
        S_GAP: state <= S_SCAN;
        S_SCAN: begin
          out_cnt <= out_cnt + AW'(1);
          // once the carry is set the coordinate is pinned past the line end
          if (!acc[CW]) acc <= acc + {1'b0, step};
          if (last_grp) state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (pipe_v == '0) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BICUBIC_EDGE_CLAMP_EN
  logic [RL-1:0] pipe_lo, pipe_h1, pipe_h2;
  logic [AW:0]   xi_p2;
  logic          lo_edge, hi1, hi2;

  always_comb begin
    xi_p2   = {1'b0, xi} + (AW + 1)'(2);
    lo_edge = (xi == '0);
    hi1     = (xi >= w_m1);
    hi2     = (xi_p2 > {1'b0, w_m1});
  end

  // Edge flags travel alongside the read so they meet the matching RAM words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_lo <= '0;
      pipe_h1 <= '0;
      pipe_h2 <= '0;
    end else begin
      pipe_lo <= {pipe_lo[RL-2:0], issue & lo_edge};
      pipe_h1 <= {pipe_h1[RL-2:0], issue & hi1};
      pipe_h2 <= {pipe_h2[RL-2:0], issue & hi2};
    end
  end
`endif

  // Sideband pipe matching the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      pipe_l <= '0;
      for (int i = 0; i < RL; i++) pipe_f[i] <= '0;
    end else begin
      pipe_v    <= {pipe_v[RL-2:0], issue};
      pipe_l    <= {pipe_l[RL-2:0], issue & last_grp};
      pipe_f[0] <= issue ? frac : '0;
      for (int i = 1; i < RL; i++) pipe_f[i] <= pipe_f[i-1];
    end
  end

  // Registered output stage with optional edge replication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_frac  <= '0;
      m_p0    <= '0;
      m_p1    <= '0;
      m_p2    <= '0;
      m_p3    <= '0;
    end else begin
      m_valid <= pipe_v[RL-1];
      m_last  <= pipe_l[RL-1];
      m_frac  <= pipe_f[RL-1];
      if (pipe_v[RL-1]) begin
`ifdef BICUBIC_EDGE_CLAMP_EN
        m_p0 <= pipe_lo[RL-1] ? ram_qB_in : ram_qA_in;
        m_p1 <= ram_qB_in;
        m_p2 <= pipe_h1[RL-1] ? ram_qB_in : ram_qC_in;
        m_p3 <= pipe_h2[RL-1] ? (pipe_h1[RL-1] ? ram_qB_in : ram_qC_in) : ram_qD_in;
`else
        m_p0 <= ram_qA_in;
        m_p1 <= ram_qB_in;
        m_p2 <= ram_qC_in;
        m_p3 <= ram_qD_in;
`endif
      end else begin
        m_p0 <= '0;
        m_p1 <= '0;
        m_p2 <= '0;
        m_p3 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bicubic_line_tap_reader.sv
// Directed bench for bicubic_line_tap_reader with a 6-cycle-latency line
// buffer model. Expectations follow BICUBIC_EDGE_CLAMP_EN when defined.
module tb_bicubic_line_tap_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] cfg_in_width = '0, cfg_out_width = '0;
  logic [18:0] cfg_step = '0;
  logic        s_valid = 1'b0;
  logic [23:0] s_data = '0;
  logic        s_ready, ram_we_out, m_valid, m_last, busy, done;
  logic [23:0] ram_data_out, ram_qA_in, ram_qB_in, ram_qC_in, ram_qD_in;
  logic [10:0] ram_addrA_out, ram_addrB_out, ram_addrC_out, ram_addrD_out;
  logic [23:0] m_p0, m_p1, m_p2, m_p3;
  logic [7:0]  m_frac;

  bicubic_line_tap_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_in_width(cfg_in_width), .cfg_out_width(cfg_out_width), .cfg_step(cfg_step),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .ram_data_out(ram_data_out), .ram_we_out(ram_we_out),
    .ram_addrA_out(ram_addrA_out), .ram_addrB_out(ram_addrB_out),
    .ram_addrC_out(ram_addrC_out), .ram_addrD_out(ram_addrD_out),
    .ram_qA_in(ram_qA_in), .ram_qB_in(ram_qB_in), .ram_qC_in(ram_qC_in), .ram_qD_in(ram_qD_in),
    .m_valid(m_valid), .m_p0(m_p0), .m_p1(m_p1), .m_p2(m_p2), .m_p3(m_p3),
    .m_frac(m_frac), .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // line buffer model: write port on B, four read ports with 6-cycle latency
  logic [23:0] mem [2048];
  logic [23:0] da [6], db [6], dc [6], dd [6];
  always @(posedge clk) begin
    if (ram_we_out) mem[ram_addrB_out] <= ram_data_out;
    da[0] <= mem[ram_addrA_out];
    db[0] <= mem[ram_addrB_out];
    dc[0] <= mem[ram_addrC_out];
    dd[0] <= mem[ram_addrD_out];
    for (int i = 1; i < 6; i++) begin
      da[i] <= da[i-1]; db[i] <= db[i-1]; dc[i] <= dc[i-1]; dd[i] <= dd[i-1];
    end
  end
  assign ram_qA_in = da[5];
  assign ram_qB_in = db[5];
  assign ram_qC_in = dc[5];
  assign ram_qD_in = dd[5];

  typedef struct {
    logic [23:0] p0, p1, p2, p3;
    logic [7:0]  frac;
    logic        last;
  } grp_t;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  grp_t        gq [$];
  logic [10:0] wa [$];
  logic [23:0] wd [$];
  int first_v, last_v, done_cyc, done_seen, n_last, start_cyc;
  logic done_busy;

  // observe outputs mid-cycle
  always @(negedge clk) begin
    if (m_valid) begin
      gq.push_back('{m_p0, m_p1, m_p2, m_p3, m_frac, m_last});
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      if (m_last) n_last++;
    end
    if (done) begin
      done_seen++;
      done_cyc  = cyc;
      done_busy = busy;
    end
    if (ram_we_out) begin
      wa.push_back(ram_addrB_out);
      wd.push_back(ram_data_out);
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic grp_t grp_at(input int i);
    grp_t z = '{24'h0, 24'h0, 24'h0, 24'h0, 8'h0, 1'b0};
    if (i < gq.size()) return gq[i];
    return z;
  endfunction

  function automatic logic [95:0] taps(input int i);
    grp_t g = grp_at(i);
    return {g.p0, g.p1, g.p2, g.p3};
  endfunction

  function automatic logic [71:0] taps_hi(input int i);
    grp_t g = grp_at(i);
    return {g.p1, g.p2, g.p3};
  endfunction

  // start a line and feed pixels k+1; optional every-other-cycle stall
  task automatic start_line(input int in_w, input int out_w, input int step, input bit stall);
    int k;
    gq.delete(); wa.delete(); wd.delete();
    first_v = -1; last_v = -1; done_cyc = -1; done_seen = 0; n_last = 0;
    @(posedge clk); #1;
    cfg_in_width  = 11'(in_w);
    cfg_out_width = 11'(out_w);
    cfg_step      = 19'(step);
    start         = 1'b1;
    start_cyc     = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    for (int g = 0; g < 400 && k < in_w && out_w != 0; g++) begin
      s_valid = stall ? ~s_valid : 1'b1;
      s_data  = 24'(k + 1);
      if (s_valid && s_ready) k++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (out_w != 0) chk("fill_count", k, in_w);
  endtask

  task automatic wait_done();
    for (int g = 0; g < 300 && done_seen == 0; g++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("done_pulses", done_seen, 1);
  endtask

  task automatic check_framing(input int n);
    chk("grp_count", gq.size(), n);
    chk("no_bubbles", last_v - first_v, n - 1);
    chk("last_count", n_last, 1);
    chk("last_on_final", grp_at(n - 1).last, 1'b1);
    chk("done_after_last", done_cyc, last_v + 1);
    chk("busy_at_done", done_busy, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", |{m_valid, m_last, busy, done, s_ready, ram_we_out, m_p0, m_p1,
                      m_p2, m_p3, m_frac, ram_addrA_out, ram_addrB_out, ram_addrC_out,
                      ram_addrD_out, ram_data_out}, 1'b0);
    rst_n = 1'b1;

    // unity scale, 8 in / 8 out
    start_line(8, 8, 'h100, 1'b0);
    wait_done();
    check_framing(8);
    chk("t1_latency", first_v - start_cyc, 17);
    chk("t1_g3", taps(3), {24'd3, 24'd4, 24'd5, 24'd6});
    chk("t1_g5_frac", grp_at(5).frac, 8'h00);
`ifdef BICUBIC_EDGE_CLAMP_EN
    chk("t1_g0", taps(0), {24'd1, 24'd1, 24'd2, 24'd3});
    chk("t1_g7", taps(7), {24'd7, 24'd8, 24'd8, 24'd8});
`else
    chk("t1_g0", taps_hi(0), {24'd1, 24'd2, 24'd3});
    chk("t1_g7", taps(7) >> 48, {24'd7, 24'd8});
`endif

    // 2x upscale, 4 in / 8 out; mem[4..7] still holds 5..8
    start_line(4, 8, 'h080, 1'b0);
    wait_done();
    check_framing(8);
    chk("t2_g0_frac", grp_at(0).frac, 8'h00);
    chk("t2_g1_frac", grp_at(1).frac, 8'h80);
    chk("t2_g7_frac", grp_at(7).frac, 8'h80);
    chk("t2_g2", taps(2), {24'd1, 24'd2, 24'd3, 24'd4});
`ifdef BICUBIC_EDGE_CLAMP_EN
    chk("t2_g0", taps(0), {24'd1, 24'd1, 24'd2, 24'd3});
    chk("t2_g7", taps(7), {24'd3, 24'd4, 24'd4, 24'd4});
`else
    chk("t2_g7", taps(7), {24'd3, 24'd4, 24'd5, 24'd6});
`endif

    // overshoot: coordinate 4.5 saturates to 3.0
    start_line(4, 4, 'h180, 1'b0);
    wait_done();
    check_framing(4);
    chk("t3_g1_frac", grp_at(1).frac, 8'h80);
    chk("t3_g2_frac", grp_at(2).frac, 8'h00);
    chk("t3_g3_frac", grp_at(3).frac, 8'h00);
`ifdef BICUBIC_EDGE_CLAMP_EN
    chk("t3_g3", taps(3), {24'd3, 24'd4, 24'd4, 24'd4});
    chk("t3_g2", taps(2), {24'd3, 24'd4, 24'd4, 24'd4});
`else
    chk("t3_g3", taps(3), {24'd3, 24'd4, 24'd5, 24'd6});
    chk("t3_g2", taps(2), {24'd3, 24'd4, 24'd5, 24'd6});
`endif

    // stalled fill
    start_line(5, 5, 'h100, 1'b1);
    wait_done();
    check_framing(5);
    chk("t4_writes", wa.size(), 5);
    for (int i = 0; i < 5 && i < wa.size(); i++) begin
      chk("t4_waddr", wa[i], 11'(i));
      chk("t4_wdata", wd[i], 24'(i + 1));
    end
    chk("t4_g2", taps(2), {24'd2, 24'd3, 24'd4, 24'd5});

    // empty line
    start_line(0, 8, 'h100, 1'b0);
    wait_done();
    chk("t5_done_cyc", done_cyc, start_cyc + 1);
    chk("t5_writes", wa.size(), 0);
    chk("t5_groups", gq.size(), 0);

    // reset mid-scan, then a clean line
    start_line(8, 8, 'h100, 1'b0);
    for (int g = 0; g < 100 && gq.size() < 2; g++) @(posedge clk);
    chk("t6_in_scan", gq.size() >= 2, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", |{m_valid, m_last, busy, done, s_ready, ram_we_out, m_p0, m_p1,
                         m_p2, m_p3, m_frac, ram_addrA_out, ram_addrB_out, ram_addrC_out,
                         ram_addrD_out, ram_data_out}, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    start_line(8, 8, 'h100, 1'b0);
    wait_done();
    check_framing(8);
    chk("t6_g3", taps(3), {24'd3, 24'd4, 24'd5, 24'd6});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
